uart_param_core: RTL
====================

// Module: uart_param_core
// PURPOSE
// Parametrised full-duplex UART core and successor to the fixed 8-bit UART top. Adds configurable
// word length, bit period, optional even/odd parity and 1 or 2 stop bits. RX side adds glitch-rejected
// start detection, frame-error and overrun detection, and a valid/ack handshake. Sits between the
// pads (Serial_In/Serial_Out) and the parallel host logic.
// PARAMETERS
// WORD_LENGTH   8    data bits per frame, 5..16, sent and received LSB first
// CLKS_PER_BIT  16   Clk cycles per bit period, >=4, must be even
// PARITY_EN     1    1: parity bit follows data; 0: no parity bit
// PARITY_ODD    0    0: even parity (bit = ^data); 1: odd parity (bit = ~^data)
// STOP_BITS     1    1 or 2 stop bits on TX; RX checks only the first stop bit
// PORTS
// Clk           in   1    single system clock, all logic on rising edge
// Reset         in   1    synchronous, active-low reset
// Parallel_In   in   WL   TX data, latched when a transmit is accepted
// Transmit      in   1    TX request; accepted when Transmit=1 and Tx_Busy=0
// Tx_Busy       out  1    high from the cycle after acceptance to the end of the last stop bit
// Serial_Out    out  1    TX line, idles high
// Serial_In     in   1    RX line, asynchronous, idles high
// Parallel_Out  out  WL   last received word, held until the next frame completes
// Flag_Rx       out  1    RX valid; set on frame completion, held until Rx_Ack
// Rx_Ack        in   1    host consumed the word; clears Flag_Rx, Parity_Error, Frame_Error, Overrun
// Parity_Error  out  1    parity mismatch on the word in Parallel_Out (0 when PARITY_EN=0)
// Frame_Error   out  1    first stop bit sampled low on the word in Parallel_Out
// Overrun       out  1    sticky; a frame completed while Flag_Rx=1 and Rx_Ack=0
// BEHAVIOUR
// - Reset (Reset=0 at a Clk edge): Serial_Out=1. Tx_Busy, Flag_Rx, Parity_Error, Frame_Error,
//   Overrun=0. Parallel_Out=0. Both FSMs go to IDLE and all counters clear, aborting any frame in flight.
// - TX FSM states: IDLE -> START -> DATA(WL bits) -> PARITY (only if PARITY_EN) -> STOP(STOP_BITS) -> IDLE.
// - TX acceptance: Transmit=1 in IDLE latches Parallel_In. Next cycle Serial_Out=0 and Tx_Busy=1.
// - TX timing: each bit holds for exactly CLKS_PER_BIT cycles.
//   Tx_Busy width = CLKS_PER_BIT*(1+WL+PARITY_EN+STOP_BITS) cycles.
//   Tx_Busy falls in the cycle after the last stop-bit cycle.
//   Transmit held high gives back-to-back frames with no idle gap beyond that 1 cycle.
//   Transmit while Tx_Busy=1 is ignored; no queuing.
// - RX input: Serial_In passes through a 2-flop synchroniser, and all RX decisions use the synced value.
// - RX FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
//   IDLE: synced low moves to START and clears the bit counter.
//   START: at count CLKS_PER_BIT/2-1, line still low moves to DATA; line high returns to IDLE (glitch).
//   DATA/PARITY/STOP: sample once every CLKS_PER_BIT cycles from the start midpoint (mid-bit).
//   Data is shifted in LSB first.
// - RX completion: at the first stop-bit sample, in one cycle:
//   Parallel_Out <= word, Flag_Rx <= 1, Parity_Error <= mismatch, Frame_Error <= ~stop.
//   The FSM returns to IDLE immediately and can detect a start half a bit later. Remaining stop
//   time is not awaited.
// - Handshake: Rx_Ack=1 with Flag_Rx=1 clears Flag_Rx and all three error flags next cycle.
//   Rx_Ack with Flag_Rx=0 has no effect.
// - Overrun: completion while Flag_Rx=1 and Rx_Ack=0 overwrites Parallel_Out and error flags and
//   sets Overrun=1.
// - Simultaneous events: completion in the same cycle as Rx_Ack gives new data, Flag_Rx stays 1,
//   and no Overrun.
// - TX and RX are independent. Loopback (Serial_Out->Serial_In) must work at any parameter set.
// - Counters: bit-period counter is $clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1.
//   Bit index counter is $clog2(WL+1) bits. No other arithmetic.
// STRUCTURE
// - uart_pkg: TX/RX state encodings (localparam), parity function (PARITY_ODD-aware), frame-length constant.
// - Sub-module uart_bit_timer: clear/enable bit-period counter with a tick output.
//   Instantiated once in TX and once in RX (RX preloads to half period for start validation).
// - TX path, RX path and synchroniser stay inline in this module.
// TESTING (bench: WL=8, CLKS_PER_BIT=16, PARITY_EN=1, even, STOP_BITS=1, 11-bit frame = 176 cycles)
// - Reset: Reset=0 for 3 cycles mid-TX and mid-RX.
//   -> Serial_Out=1, Tx_Busy=0, Flag_Rx=0, Parallel_Out=0; partial RX frame never flagged.
// - TX 0xA5: Transmit pulse.
//   -> Serial_Out = 0,1,0,1,0,0,1,0,1,0(parity),1, 16 cycles each; Tx_Busy high exactly 176 cycles.
// - Loopback 0x3C then 0xC3 with Transmit held high and Rx_Ack after each.
//   -> Parallel_Out 0x3C then 0xC3, all error flags 0, no Overrun.
// - Errors: inject 0x01 with parity bit 0 -> Parity_Error=1.
//   Inject 0x55 with stop bit 0 -> Frame_Error=1. Data is correct in both cases.
// - Overrun: frames 0x11, 0x22 with no Rx_Ack -> Parallel_Out=0x22, Overrun=1.
//   Rx_Ack -> Flag_Rx=0, Overrun=0 next cycle.
// - Glitch and ack race: Serial_In low for 4 cycles -> no reception.
//   Rx_Ack coincident with a completion -> Flag_Rx=1, Overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: FSM state encoding,
// parity helper and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int MAX_WORD_LENGTH = 16;

  // Data is zero-extended to 16 bits, which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_WORD_LENGTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic int frame_bits(input int word_length, input int parity_en, input int stop_bits);
    return 1 + word_length + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with clear, half-period preload and a tick on the last
// count of each period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_preload,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick    = i_enable & ~i_clear & ~i_preload & w_at_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_preload) begin
      r_count <= HALF;
    end else if (i_enable) begin
      r_count <= w_at_last ? '0 : r_count + ONE;
    end
  end

endmodule

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: TX framer, synchronised RX deframer with
// glitch-rejected start, parity/frame/overrun flags and valid/ack handshake.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [WORD_LENGTH-1:0] Parallel_In,
  input  logic                   Transmit,
  output logic                   Tx_Busy,
  output logic                   Serial_Out,
  input  logic                   Serial_In,
  output logic [WORD_LENGTH-1:0] Parallel_Out,
  output logic                   Flag_Rx,
  input  logic                   Rx_Ack,
  output logic                   Parity_Error,
  output logic                   Frame_Error,
  output logic                   Overrun
);

  localparam int BW = $clog2(WORD_LENGTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WORD_LENGTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] CNT_ONE   = BW'(1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  uart_state_t            r_tx_state, w_tx_state_next;
  logic [WORD_LENGTH-1:0] r_tx_shift, w_tx_shift_next;
  logic                   r_tx_par, w_tx_par_next;
  logic [BW-1:0]          r_tx_cnt, w_tx_cnt_next;
  logic                   r_tx_line, w_tx_line_next;
  logic                   w_tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .i_clk    (Clk),
    .i_rst_n  (Reset),
    .i_clear  (r_tx_state == ST_IDLE),
    .i_preload(1'b0),
    .i_enable (r_tx_state != ST_IDLE),
    .o_tick   (w_tx_tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_par   <= w_tx_par_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_line  <= w_tx_line_next;
    end
  end

  // Serial_Out is registered: each bit value is loaded on the tick ending the previous bit.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_shift_next = r_tx_shift;
    w_tx_par_next   = r_tx_par;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_line_next  = r_tx_line;
    case (r_tx_state)
      ST_IDLE: begin
        w_tx_line_next = 1'b1;
        if (Transmit) begin
          w_tx_state_next = ST_START;
          w_tx_shift_next = Parallel_In;
          w_tx_par_next   = parity_bit(16'(Parallel_In), ODD);
          w_tx_cnt_next   = '0;
          w_tx_line_next  = 1'b0;
        end
      end
      ST_START: begin
        if (w_tx_tick) begin
          w_tx_state_next = ST_DATA;
          w_tx_line_next  = r_tx_shift[0];
          w_tx_shift_next = {1'b0, r_tx_shift[WORD_LENGTH-1:1]};
          w_tx_cnt_next   = '0;
        end
      end
      ST_DATA: begin
        if (w_tx_tick) begin
          if (r_tx_cnt == LAST_DATA) begin
            w_tx_cnt_next = '0;
            if (PARITY_EN != 0) begin
              w_tx_state_next = ST_PARITY;
              w_tx_line_next  = r_tx_par;
            end else begin
              w_tx_state_next = ST_STOP;
              w_tx_line_next  = 1'b1;
            end
          end else begin
            w_tx_line_next  = r_tx_shift[0];
            w_tx_shift_next = {1'b0, r_tx_shift[WORD_LENGTH-1:1]};
            w_tx_cnt_next   = r_tx_cnt + CNT_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (w_tx_tick) begin
          w_tx_state_next = ST_STOP;
          w_tx_line_next  = 1'b1;
          w_tx_cnt_next   = '0;
        end
      end
      ST_STOP: begin
        if (w_tx_tick) begin
          if (r_tx_cnt == LAST_STOP) begin
            w_tx_state_next = ST_IDLE;
          end else begin
            w_tx_cnt_next = r_tx_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_tx_state_next = ST_IDLE;
        w_tx_line_next  = 1'b1;
      end
    endcase
  end

  assign Serial_Out = r_tx_line;
  assign Tx_Busy    = (r_tx_state != ST_IDLE);

  logic [1:0]             r_rx_sync;
  logic                   w_rx_line;
  uart_state_t            r_rx_state, w_rx_state_next;
  logic [WORD_LENGTH-1:0] r_rx_shift, w_rx_shift_next;
  logic                   r_rx_par, w_rx_par_next;
  logic [BW-1:0]          r_rx_cnt, w_rx_cnt_next;
  logic [WORD_LENGTH-1:0] r_rx_word, w_rx_word_next;
  logic                   r_rx_flag, w_rx_flag_next;
  logic                   r_rx_perr, w_rx_perr_next;
  logic                   r_rx_ferr, w_rx_ferr_next;
  logic                   r_rx_ovr, w_rx_ovr_next;
  logic                   w_rx_tick;
  logic                   w_rx_done;

  assign w_rx_line = r_rx_sync[1];

  // Preloading to half a period makes the first tick land on the start-bit midpoint.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .i_clk    (Clk),
    .i_rst_n  (Reset),
    .i_clear  (1'b0),
    .i_preload(r_rx_state == ST_IDLE),
    .i_enable (r_rx_state != ST_IDLE),
    .o_tick   (w_rx_tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= ST_IDLE;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_word  <= '0;
      r_rx_flag  <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], Serial_In};
      r_rx_state <= w_rx_state_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_par   <= w_rx_par_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_word  <= w_rx_word_next;
      r_rx_flag  <= w_rx_flag_next;
      r_rx_perr  <= w_rx_perr_next;
      r_rx_ferr  <= w_rx_ferr_next;
      r_rx_ovr   <= w_rx_ovr_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_shift_next = r_rx_shift;
    w_rx_par_next   = r_rx_par;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_done       = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (!w_rx_line) begin
          w_rx_state_next = ST_START;
          w_rx_cnt_next   = '0;
        end
      end
      ST_START: begin
        if (w_rx_tick) begin
          w_rx_state_next = w_rx_line ? ST_IDLE : ST_DATA;
          w_rx_cnt_next   = '0;
        end
      end
      ST_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_next = {w_rx_line, r_rx_shift[WORD_LENGTH-1:1]};
          if (r_rx_cnt == LAST_DATA) begin
            w_rx_cnt_next   = '0;
            w_rx_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_rx_cnt_next = r_rx_cnt + CNT_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (w_rx_tick) begin
          w_rx_par_next   = w_rx_line;
          w_rx_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_rx_tick) begin
          w_rx_done       = 1'b1;
          w_rx_state_next = ST_IDLE;
        end
      end
      default: w_rx_state_next = ST_IDLE;
    endcase
  end

  // Completion wins over a coincident ack; the ack only suppresses the overrun.
  always_comb begin
    w_rx_word_next = r_rx_word;
    w_rx_flag_next = r_rx_flag;
    w_rx_perr_next = r_rx_perr;
    w_rx_ferr_next = r_rx_ferr;
    w_rx_ovr_next  = r_rx_ovr;
    if (w_rx_done) begin
      w_rx_word_next = r_rx_shift;
      w_rx_flag_next = 1'b1;
      w_rx_perr_next = (PARITY_EN != 0) && (r_rx_par != parity_bit(16'(r_rx_shift), ODD));
      w_rx_ferr_next = ~w_rx_line;
      w_rx_ovr_next  = r_rx_flag & ~Rx_Ack;
    end else if (Rx_Ack && r_rx_flag) begin
      w_rx_flag_next = 1'b0;
      w_rx_perr_next = 1'b0;
      w_rx_ferr_next = 1'b0;
      w_rx_ovr_next  = 1'b0;
    end
  end

  assign Parallel_Out = r_rx_word;
  assign Flag_Rx      = r_rx_flag;
  assign Parity_Error = r_rx_perr;
  assign Frame_Error  = r_rx_ferr;
  assign Overrun      = r_rx_ovr;

endmodule
